// File: rtl/sd_cmd_pkg.sv
// Shared definitions for the SD command physical layer.
// Contents: frame/command lengths, CRC7 polynomial, field offsets within the
// received response (start bit excluded), and the one-hot FSM state encoding.
package sd_cmd_pkg;

  localparam int unsigned FrameLen = 48;
  localparam int unsigned CmdLen   = 38;
  localparam logic [6:0]  Crc7Poly = 7'h09;

  // Offsets into the 47 response bits that follow the start bit.
  localparam int unsigned RxTxBit  = 46;
  localparam int unsigned RxIdxMsb = 45;
  localparam int unsigned RxIdxLsb = 40;
  localparam int unsigned RxArgLsb = 8;
  localparam int unsigned RxCrcMsb = 7;
  localparam int unsigned RxCrcLsb = 1;
  localparam int unsigned RxEndBit = 0;

  typedef enum logic [7:0] {
    StIdle      = 8'b0000_0001,
    StAck       = 8'b0000_0010,
    StSend      = 8'b0000_0100,
    StWaitResp  = 8'b0000_1000,
    StReceive   = 8'b0001_0000,
    StCheck     = 8'b0010_0000,
    StHandshake = 8'b0100_0000,
    StRelease   = 8'b1000_0000
  } phy_state_e;

endpackage

// File: rtl/crc7_serial.sv
// Serial CRC7 (x^7 + x^3 + 1), MSB first, initial value 0.
// Ports:
//   clk    - clock
//   reset  - asynchronous active-low reset
//   clear  - synchronous clear to 0 (wins over enable)
//   enable - absorb bit_in this cycle
//   bit_in - serial data bit
//   crc    - current CRC register
module crc7_serial
  import sd_cmd_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       enable,
  input  logic       bit_in,
  output logic [6:0] crc
);

  logic [6:0] crc_q, crc_d;
  logic       fb;

  always_comb begin
    crc_d = crc_q;
    fb    = bit_in ^ crc_q[6];
    if (clear) begin
      crc_d = '0;
    end else if (enable) begin
      crc_d = {crc_q[5:0], 1'b0} ^ (fb ? Crc7Poly : 7'h00);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      crc_q <= '0;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/cmd_physical.sv
// Card-side SD CMD line PHY: serializes a 38-bit command into a 48-bit frame,
// receives the 48-bit short response, checks it and returns it via REQ/ACK.
// Ports:
//   CLK_SD_card  - clock, one CMD bit per cycle
//   reset        - asynchronous active-low reset
//   REQ_in       - command request (level) from the master
//   ACK_in       - master acknowledge of the response
//   cmd_to_send  - [37:32] index, [31:0] argument
//   cmd_pin_in   - sampled CMD line
//   cmd_pin_out  - CMD drive value; cmd_pin_oe - CMD output enable
//   ACK_out      - one-cycle command-accepted pulse
//   REQ_out      - response ready (level)
//   cmd_response - received index/argument; cmd_error - response error
//   phy_busy     - FSM not idle
module cmd_physical
  import sd_cmd_pkg::*;
#(
  parameter int unsigned NCR_MAX     = 64,
  parameter bit          CHECK_INDEX = 1'b1
) (
  input  logic              CLK_SD_card,
  input  logic              reset,
  input  logic              REQ_in,
  input  logic              ACK_in,
  input  logic [CmdLen-1:0] cmd_to_send,
  input  logic              cmd_pin_in,
  output logic              cmd_pin_out,
  output logic              cmd_pin_oe,
  output logic              ACK_out,
  output logic              REQ_out,
  output logic [CmdLen-1:0] cmd_response,
  output logic              cmd_error,
  output logic              phy_busy
);

  localparam int unsigned NcrW = $clog2(NCR_MAX + 1);

  phy_state_e          state_q, state_d;
  logic [FrameLen-1:0] tx_q, tx_d;
  logic [FrameLen-2:0] rx_q, rx_d;
  logic [5:0]          bit_cnt_q, bit_cnt_d;
  logic [NcrW-1:0]     ncr_q, ncr_d;
  logic [5:0]          idx_q, idx_d;
  logic                pin_out_q, pin_out_d, oe_q, oe_d, ack_q, ack_d;
  logic                req_q, req_d, err_q, err_d, busy_q, busy_d;
  logic [CmdLen-1:0]   resp_q, resp_d;
  logic                crc_clear, crc_en, crc_bit;
  logic [6:0]          crc;

  // One CRC engine shared: TX frame during SEND, response during RECEIVE.
  crc7_serial u_crc (
    .clk    (CLK_SD_card),
    .reset  (reset),
    .clear  (crc_clear),
    .enable (crc_en),
    .bit_in (crc_bit),
    .crc    (crc)
  );

  always_comb begin
    state_d   = state_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    bit_cnt_d = bit_cnt_q;
    ncr_d     = ncr_q;
    idx_d     = idx_q;
    pin_out_d = pin_out_q;
    oe_d      = oe_q;
    ack_d     = ack_q;
    req_d     = req_q;
    err_d     = err_q;
    resp_d    = resp_q;
    crc_clear = 1'b0;
    crc_en    = 1'b0;
    crc_bit   = 1'b0;
    unique case (state_q)
      StIdle: begin
        crc_clear = 1'b1;
        if (REQ_in) begin
          // CRC slot left zero; filled in on the fly once 40 bits have gone out.
          tx_d    = {1'b0, 1'b1, cmd_to_send, 7'h00, 1'b1};
          idx_d   = cmd_to_send[37:32];
          resp_d  = '0;
          err_d   = 1'b0;
          ack_d   = 1'b1;
          state_d = StAck;
        end
      end
      StAck: begin
        ack_d     = 1'b0;
        bit_cnt_d = 6'd47;
        oe_d      = 1'b1;
        pin_out_d = tx_q[47];
        tx_d      = {tx_q[46:0], 1'b0};
        crc_en    = 1'b1;
        crc_bit   = tx_q[47];
        state_d   = StSend;
      end
      StSend: begin
        // bit_cnt_q is the index of the bit currently on the pin.
        if (bit_cnt_q == 6'd0) begin
          oe_d      = 1'b0;
          pin_out_d = 1'b1;
          ncr_d     = '0;
          state_d   = StWaitResp;
        end else begin
          bit_cnt_d = bit_cnt_q - 6'd1;
          if (bit_cnt_q == 6'd8) begin
            // Next bit is CRC[6]; splice the finished CRC into the zeroed slot.
            pin_out_d = crc[6];
            tx_d      = {crc[5:0], tx_q[40:0], 1'b0};
          end else begin
            pin_out_d = tx_q[47];
            tx_d      = {tx_q[46:0], 1'b0};
            crc_en    = (bit_cnt_q >= 6'd9);
            crc_bit   = tx_q[47];
          end
        end
      end
      StWaitResp: begin
        if (!cmd_pin_in) begin
          crc_clear = 1'b1;
          bit_cnt_d = 6'd46;
          state_d   = StReceive;
        end else if (ncr_q == NcrW'(NCR_MAX - 1)) begin
          err_d   = 1'b1;
          resp_d  = '0;
          req_d   = 1'b1;
          state_d = StHandshake;
        end else begin
          ncr_d = ncr_q + 1'b1;
        end
      end
      StReceive: begin
        rx_d    = {rx_q[45:0], cmd_pin_in};
        crc_en  = (bit_cnt_q >= 6'd8);
        crc_bit = cmd_pin_in;
        if (bit_cnt_q == 6'd0) begin
          state_d = StCheck;
        end else begin
          bit_cnt_d = bit_cnt_q - 6'd1;
        end
      end
      StCheck: begin
        err_d = rx_q[RxTxBit] | ~rx_q[RxEndBit] | (rx_q[RxCrcMsb:RxCrcLsb] != crc) |
                (CHECK_INDEX && (rx_q[RxIdxMsb:RxIdxLsb] != idx_q));
        resp_d  = rx_q[RxIdxMsb:RxArgLsb];
        req_d   = 1'b1;
        state_d = StHandshake;
      end
      StHandshake: begin
        if (ACK_in) begin
          req_d   = 1'b0;
          state_d = StRelease;
        end
      end
      StRelease: begin
        if (!REQ_in) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge CLK_SD_card or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      tx_q      <= '0;
      rx_q      <= '0;
      bit_cnt_q <= '0;
      ncr_q     <= '0;
      idx_q     <= '0;
      pin_out_q <= 1'b1;
      oe_q      <= 1'b0;
      ack_q     <= 1'b0;
      req_q     <= 1'b0;
      err_q     <= 1'b0;
      resp_q    <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      bit_cnt_q <= bit_cnt_d;
      ncr_q     <= ncr_d;
      idx_q     <= idx_d;
      pin_out_q <= pin_out_d;
      oe_q      <= oe_d;
      ack_q     <= ack_d;
      req_q     <= req_d;
      err_q     <= err_d;
      resp_q    <= resp_d;
      busy_q    <= busy_d;
    end
  end

  assign cmd_pin_out  = pin_out_q;
  assign cmd_pin_oe   = oe_q;
  assign ACK_out      = ack_q;
  assign REQ_out      = req_q;
  assign cmd_response = resp_q;
  assign cmd_error    = err_q;
  assign phy_busy     = busy_q;

endmodule

// File: tb/tb_cmd_physical.sv
module tb_cmd_physical;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_in = 1'b0;
  logic        ack_in = 1'b0;
  logic        pin_in = 1'b1;
  logic [37:0] cmd = '0;

  logic        pin_out, oe, ack_out, req_out, err, busy;
  logic [37:0] resp;
  logic        ni_pin_out, ni_oe, ni_ack_out, ni_req_out, ni_err, ni_busy;
  logic [37:0] ni_resp;

  typedef struct packed {
    logic [37:0] resp;
    logic        err;
    logic        err_ni;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  cmd_physical #(.NCR_MAX(64), .CHECK_INDEX(1'b1)) u_dut (
    .CLK_SD_card (clk),     .reset       (rst_n),   .REQ_in      (req_in),
    .ACK_in      (ack_in),  .cmd_to_send (cmd),     .cmd_pin_in  (pin_in),
    .cmd_pin_out (pin_out), .cmd_pin_oe  (oe),      .ACK_out     (ack_out),
    .REQ_out     (req_out), .cmd_response(resp),    .cmd_error   (err),
    .phy_busy    (busy)
  );

  cmd_physical #(.NCR_MAX(64), .CHECK_INDEX(1'b0)) u_dut_ni (
    .CLK_SD_card (clk),        .reset       (rst_n),      .REQ_in      (req_in),
    .ACK_in      (ack_in),     .cmd_to_send (cmd),        .cmd_pin_in  (pin_in),
    .cmd_pin_out (ni_pin_out), .cmd_pin_oe  (ni_oe),      .ACK_out     (ni_ack_out),
    .REQ_out     (ni_req_out), .cmd_response(ni_resp),    .cmd_error   (ni_err),
    .phy_busy    (ni_busy)
  );

  function automatic logic [6:0] crc7(input logic [39:0] d);
    logic [6:0] c;
    logic       fb;
    c = '0;
    for (int i = 39; i >= 0; i--) begin
      fb = d[i] ^ c[6];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  function automatic logic [47:0] mk_resp(input logic tbit, input logic [5:0] idx,
                                          input logic [31:0] arg);
    logic [39:0] h;
    h = {1'b0, tbit, idx, arg};
    return {h, crc7(h), 1'b1};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge. Drives one full command/response exchange.
  task automatic run_cmd(input string tag, input logic [37:0] c, input logic [47:0] exp_stream,
                         input bit respond, input logic [47:0] r, input int dly,
                         input int exp_req_at, input bit drop_early, input exp_t ex);
    int          ack_cnt;
    int          oe_cnt;
    int          off_idx;
    bit          oe_seen;
    bit          got;
    logic [47:0] stream;
    exp_t        e;
    ack_cnt = 0;
    oe_cnt  = 0;
    off_idx = -1;
    oe_seen = 0;
    got     = 0;
    stream  = '0;
    sb.push_back(ex);
    req_in = 1'b1;
    cmd    = c;
    @(negedge clk);
    chk({tag, "_ack_latency"}, ack_out, 1);
    if (ack_out) ack_cnt++;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      if (ack_out) ack_cnt++;
      if (oe) begin
        stream = {stream[46:0], pin_out};
        oe_cnt++;
        oe_seen = 1;
        if (drop_early && oe_cnt == 10) req_in = 1'b0;
      end else if (oe_seen) begin
        off_idx++;
      end
      if (req_out) begin
        got = 1;
        break;
      end
      pin_in = 1'b1;
      if (respond && off_idx >= dly && off_idx < dly + 48) pin_in = r[47-(off_idx-dly)];
    end
    pin_in = 1'b1;
    chk({tag, "_req_out_seen"}, got, 1);
    chk({tag, "_ack_pulses"}, ack_cnt, 1);
    chk({tag, "_oe_cycles"}, oe_cnt, 48);
    chk({tag, "_stream"}, stream, exp_stream);
    if (exp_req_at >= 0) chk({tag, "_req_timing"}, off_idx, exp_req_at);
    e = sb.pop_front();
    if (got) begin
      chk({tag, "_response"}, resp, e.resp);
      chk({tag, "_error"}, err, e.err);
      chk({tag, "_error_noidx"}, ni_err, e.err_ni);
      ack_in = 1'b1;
      @(negedge clk);
      chk({tag, "_req_clear"}, req_out, 0);
      chk({tag, "_resp_stable"}, resp, e.resp);
      ack_in = 1'b0;
      req_in = 1'b0;
      @(negedge clk);
      chk({tag, "_idle"}, busy, 0);
    end else begin
      req_in = 1'b0;
      rst_n  = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog_timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [47:0] r_good;
    logic [47:0] r;
    repeat (3) @(negedge clk);
    chk("rst_pin_out", pin_out, 1);
    chk("rst_oe", oe, 0);
    chk("rst_ack", ack_out, 0);
    chk("rst_req", req_out, 0);
    chk("rst_resp", resp, 0);
    chk("rst_err", err, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // CMD0, card silent: timeout 64 cycles after the end bit.
    run_cmd("cmd0_noresp", 38'h00_00000000, 48'h40_0000_0000_95, 0, '1, 0, 64, 0,
            '{resp: 38'h0, err: 1'b1, err_ni: 1'b1});

    r_good = 48'h08_0000_01AA_13;
    run_cmd("cmd8_good", 38'h08_000001AA, 48'h48_0000_01AA_87, 1, r_good, 5, -1, 0,
            '{resp: 38'h08_000001AA, err: 1'b0, err_ni: 1'b0});

    run_cmd("cmd8_badcrc", 38'h08_000001AA, 48'h48_0000_01AA_87, 1, 48'h08_0000_01AA_15, 5,
            -1, 0, '{resp: 38'h08_000001AA, err: 1'b1, err_ni: 1'b1});

    r = mk_resp(1'b0, 6'h09, 32'h0000_01AA);
    run_cmd("cmd8_badidx", 38'h08_000001AA, 48'h48_0000_01AA_87, 1, r, 0, -1, 0,
            '{resp: 38'h09_000001AA, err: 1'b1, err_ni: 1'b0});

    r = mk_resp(1'b1, 6'h08, 32'h0000_01AA);
    run_cmd("cmd8_tbit", 38'h08_000001AA, 48'h48_0000_01AA_87, 1, r, 2, -1, 1,
            '{resp: 38'h08_000001AA, err: 1'b1, err_ni: 1'b1});

    r = mk_resp(1'b0, 6'h08, 32'h0000_01AA);
    r[0] = 1'b0;
    run_cmd("cmd8_endbit", 38'h08_000001AA, 48'h48_0000_01AA_87, 1, r, 7, -1, 0,
            '{resp: 38'h08_000001AA, err: 1'b1, err_ni: 1'b1});

    r = mk_resp(1'b0, 6'h11, 32'hDEAD_BEEF);
    run_cmd("cmd17", 38'h11_DEADBEEF, {2'b01, 38'h11_DEADBEEF,
            crc7({2'b01, 38'h11_DEADBEEF}), 1'b1}, 1, r, 12, -1, 0,
            '{resp: 38'h11_DEADBEEF, err: 1'b0, err_ni: 1'b0});

    // Reset in the middle of SEND.
    req_in = 1'b1;
    cmd    = 38'h08_000001AA;
    repeat (12) @(negedge clk);
    chk("pre_rst_oe", oe, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_oe", oe, 0);
    chk("midrst_pin_out", pin_out, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_ack", ack_out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_cmd("after_rst", 38'h08_000001AA, 48'h48_0000_01AA_87, 1, r_good, 3, -1, 0,
            '{resp: 38'h08_000001AA, err: 1'b0, err_ni: 1'b0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
